// File: rtl/jk_counter.sv
// jk_counter -- N-bit synchronous up/down counter built from JK flip-flops.
//
// Each state bit is a JK flop with asynchronous clear. A gate-level J/K
// excitation network derives per-bit J/K from the current count and the
// control inputs: load forces J=d, K=~d; counting toggles bit i when every
// lower bit is at its terminal value for the current direction.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high clear of q and wrapped
//   en       count enable
//   load     parallel load (overrides en)
//   up       direction, 1 = increment, 0 = decrement
//   d        parallel load value
//   q        registered count
//   tc       combinational terminal count for the current direction
//   wrapped  registered one-cycle pulse after a wrap edge
//
// Configuration macro: JK_COUNTER_SAT_EN -- when defined the counter
// saturates at terminal count instead of wrapping, and wrapped stays low.

module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= 1'b0;
    else       q <= (j & ~q) | (~k & q);
endmodule

module jk_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);
  logic [WIDTH-1:0] match;  // bit sits at its terminal value for this direction
  logic [WIDTH-1:0] t;      // toggle request per bit
  logic [WIDTH-1:0] j, k;
  logic             cnt;
  logic             wrap_next;

  assign match = up ? q : ~q;
  assign tc    = &match;

`ifdef JK_COUNTER_SAT_EN
  // Freeze at terminal count; load still gets through.
  assign cnt       = en & ~load & ~tc;
  assign wrap_next = 1'b0;
`else
  assign cnt       = en & ~load;
  assign wrap_next = en & ~load & tc;
`endif

  // Toggle term is a flat AND over lower bits rather than a ripple chain,
  // so no bit of t feeds another.
  for (genvar i = 0; i < WIDTH; i++) begin : g_t
    if (i == 0) begin : g_lsb
      assign t[i] = cnt;
    end else begin : g_up
      assign t[i] = cnt & (&match[i-1:0]);
    end
  end

  assign j = load ? d  : t;
  assign k = load ? ~d : t;

  jk_ff u_ff [WIDTH-1:0] (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) wrapped <= 1'b0;
    else       wrapped <= wrap_next;
endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4). The stimulus process pushes
// the hand-computed post-edge state for every edge it drives; the monitor
// pops and compares just after each rising edge. Asynchronous reset
// behaviour is checked directly between edges.

module tb_jk_counter;
  typedef struct packed {
    logic [3:0] q;
    logic       wrapped;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, en, load, up;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrapped;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   edge_no = 0;

  jk_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .up      (up),
    .d       (d),
    .q       (q),
    .tc      (tc),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input exp_t act, input exp_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got q=%0d wrapped=%b tc=%b, want q=%0d wrapped=%b tc=%b",
                  name, act.q, act.wrapped, act.tc, exp.q, exp.wrapped, exp.tc);
  endfunction

  // Monitor: every rising edge is an output event.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    edge_no++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{q: q, wrapped: wrapped, tc: tc};
      check($sformatf("edge%0d", edge_no), a, e);
    end
  end

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] dv, input logic [3:0] eq, input logic ew,
                      input logic et);
    @(negedge clk);
    reset = r; load = l; en = e; up = u; d = dv;
    sb.push_back('{q: eq, wrapped: ew, tc: et});
    @(posedge clk);
  endtask

  initial begin
    exp_t a;
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
    #1;
    a = '{q: q, wrapped: wrapped, tc: tc};
    check("reset_async_t0", a, '{q: 4'd0, wrapped: 1'b0, tc: 1'b0});

    // Reset held across edges with en=1
    repeat (3) step(1, 0, 1, 1, 0, 4'd0, 0, 0);

    // Up count through wrap
    for (int i = 1; i <= 16; i++) begin
`ifdef JK_COUNTER_SAT_EN
      if (i == 16) step(0, 0, 1, 1, 0, 4'd15, 0, 1);
`else
      if (i == 16) step(0, 0, 1, 1, 0, 4'd0, 1, 0);
`endif
      else         step(0, 0, 1, 1, 0, 4'(i), 0, (i == 15));
    end

    // Down count and direction flip
    step(0, 1, 0, 0, 4'd2, 4'd2, 0, 0);
    step(0, 0, 1, 0, 0, 4'd1, 0, 0);
    step(0, 0, 1, 0, 0, 4'd0, 0, 1);
`ifdef JK_COUNTER_SAT_EN
    step(0, 0, 1, 0, 0, 4'd0, 0, 1);
    step(0, 0, 1, 1, 0, 4'd1, 0, 0);
`else
    step(0, 0, 1, 0, 0, 4'd15, 1, 0);
    step(0, 0, 1, 1, 0, 4'd0, 1, 0);
`endif

    // Load priority over en, then hold
    step(0, 1, 0, 1, 4'd7, 4'd7, 0, 0);
    step(0, 1, 1, 1, 4'd12, 4'd12, 0, 0);
    repeat (4) step(0, 0, 0, 1, 4'd3, 4'd12, 0, 0);

    // Load at terminal count
    step(0, 1, 0, 1, 4'd15, 4'd15, 0, 1);
    step(0, 1, 1, 1, 4'd3, 4'd3, 0, 0);

    // Run into the top from 14
    step(0, 1, 0, 1, 4'd14, 4'd14, 0, 0);
`ifdef JK_COUNTER_SAT_EN
    repeat (3) step(0, 0, 1, 1, 0, 4'd15, 0, 1);
    step(0, 0, 1, 0, 0, 4'd14, 0, 0);
`else
    step(0, 0, 1, 1, 0, 4'd15, 0, 1);
    step(0, 0, 1, 1, 0, 4'd0, 1, 0);
    step(0, 0, 1, 1, 0, 4'd1, 0, 0);
    step(0, 0, 1, 0, 0, 4'd0, 0, 1);
`endif

    // Asynchronous reset between edges at q=5
    step(0, 1, 0, 1, 4'd5, 4'd5, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    a = '{q: q, wrapped: wrapped, tc: tc};
    check("reset_async_q5", a, '{q: 4'd0, wrapped: 1'b0, tc: 1'b0});
    up = 1'b0;
    #1;
    a = '{q: q, wrapped: wrapped, tc: tc};
    check("reset_tc_down", a, '{q: 4'd0, wrapped: 1'b0, tc: 1'b1});
    step(1, 0, 1, 1, 0, 4'd0, 0, 0);
    step(0, 0, 1, 1, 0, 4'd1, 0, 0);
    step(0, 0, 1, 1, 0, 4'd2, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int n = 0; n < 5 && sb.size() > 0; n++) @(posedge clk);
    #2;
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending entries, want 0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
